// File: rtl/fifo_loader.sv
// Fetches DEPTH consecutive words from a stalling memory (one read in flight) and
// shifts them into a delay buffer. Define FIFO_LOADER_STALL_CNT_EN to add a stall counter.
module fifo_loader #(
  parameter int DEPTH  = 8,
  parameter int BITS   = 64,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  input  logic              mem_waitrequest,
  input  logic [BITS-1:0]   mem_readdata,
  input  logic              mem_readdatavalid,
  output logic [BITS-1:0]   fifo_d,
  output logic              fifo_en,
  output logic              busy,
`ifdef FIFO_LOADER_STALL_CNT_EN
  output logic [15:0]       stall_cnt,
`endif
  output logic              done
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(BITS / 8);
  localparam logic [CNT_W-1:0]  LAST_IDX   = CNT_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [BITS-1:0]   fifo_d_q, fifo_d_d;
  logic              fifo_en_q, fifo_en_d;
  logic [ADDR_W-1:0] req_addr;

  // Address is derived from the latched base and word count, so it stays put during stalls.
  assign req_addr = base_q + ADDR_W'(count_q) * WORD_BYTES;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    count_d     = count_q;
    fifo_d_d    = fifo_d_q;
    fifo_en_d   = 1'b0;
    mem_read    = 1'b0;
    mem_address = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d  = base_addr;
          count_d = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        mem_read    = 1'b1;
        mem_address = req_addr;
        if (!mem_waitrequest) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_readdatavalid) begin
          fifo_d_d  = mem_readdata;
          fifo_en_d = 1'b1;
          count_d   = count_q + CNT_W'(1);
          state_d   = (count_q == LAST_IDX) ? S_DONE : S_REQ;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      count_q   <= '0;
      fifo_d_q  <= '0;
      fifo_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      count_q   <= count_d;
      fifo_d_q  <= fifo_d_d;
      fifo_en_q <= fifo_en_d;
    end
  end

  assign fifo_d  = fifo_d_q;
  assign fifo_en = fifo_en_q;
  assign busy    = (state_q != S_IDLE);
  // The final strobe is registered on the WAIT->DONE edge, so it lands in the DONE cycle.
  assign done    = (state_q == S_DONE);

`ifdef FIFO_LOADER_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == S_IDLE && start) begin
      stall_d = '0;
    end else if (mem_read && mem_waitrequest && stall_q != 16'hFFFF) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_fifo_loader.sv
// Randomised bench for fifo_loader: a memory model answers reads, a scoreboard
// holds the words and addresses each load must produce, a monitor checks the strobes.
module tb_fifo_loader;
  localparam int DEPTH  = 8;
  localparam int BITS   = 64;
  localparam int ADDR_W = 32;
  localparam int TMO    = 2000;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_read;
  logic              mem_waitrequest = 1'b0;
  logic [BITS-1:0]   mem_readdata = '0;
  logic              mem_readdatavalid = 1'b0;
  logic [BITS-1:0]   fifo_d;
  logic              fifo_en;
  logic              busy;
  logic              done;
`ifdef FIFO_LOADER_STALL_CNT_EN
  logic [15:0]       stall_cnt;
`endif

  fifo_loader #(.DEPTH(DEPTH), .BITS(BITS), .ADDR_W(ADDR_W)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .base_addr         (base_addr),
    .mem_address       (mem_address),
    .mem_read          (mem_read),
    .mem_waitrequest   (mem_waitrequest),
    .mem_readdata      (mem_readdata),
    .mem_readdatavalid (mem_readdatavalid),
    .fifo_d            (fifo_d),
    .fifo_en           (fifo_en),
    .busy              (busy),
`ifdef FIFO_LOADER_STALL_CNT_EN
    .stall_cnt         (stall_cnt),
`endif
    .done              (done)
  );

  // clock
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // scoreboard
  logic [BITS-1:0]   exp_q[$];
  logic              last_q[$];
  logic [ADDR_W-1:0] addr_exp_q[$];
  logic [BITS-1:0]   last_d = '0;

  logic [31:0]       salt = 32'h1234_5678;
  int                pend = -1;
  logic [ADDR_W-1:0] pend_addr = '0;
  int                req_idx = 0;
  int                stall_left = 0;
  int                stall_seen = 0;
  int                words_seen = 0;
  int                loads_done = 0;
  int                ld0 = 0;
  bit                stall_mode = 1'b0;
  bit                rand_wait = 1'b0;
  bit                rand_lat = 1'b0;
  bit                spur_en = 1'b0;
  bit                start_noise = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: event not as required at %0t", nm, $time);
  endtask

  // Memory contents: any fixed function of address, varied per load by salt.
  function automatic logic [BITS-1:0] mem_data(input logic [ADDR_W-1:0] a);
    return {a ^ salt, ~a ^ {salt[15:0], salt[31:16]}};
  endfunction

  // memory model: drives waitrequest/readdatavalid at negedges, checks addresses
  initial begin
    logic [ADDR_W-1:0] ea;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = -1;
        mem_readdatavalid = 1'b0;
        mem_waitrequest = 1'b0;
        continue;
      end
      mem_readdatavalid = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          mem_readdatavalid = 1'b1;
          mem_readdata = mem_data(pend_addr);
          pend = -1;
        end
      end else if (spur_en && ($urandom_range(0, 3) == 0)) begin
        mem_readdatavalid = 1'b1;
        mem_readdata = {$urandom, $urandom};
      end
      if (mem_read) begin
        if (pend >= 0) begin
          mem_waitrequest = 1'b0;
          fail("second_outstanding_read");
        end else if (addr_exp_q.size() == 0) begin
          mem_waitrequest = 1'b0;
          fail("unexpected_read");
        end else begin
          if (stall_mode && req_idx == 1 && stall_left > 0) begin
            mem_waitrequest = 1'b1;
            stall_left--;
          end else begin
            mem_waitrequest = rand_wait && ($urandom_range(0, 2) == 0);
          end
          if (mem_waitrequest) begin
            stall_seen++;
            check("addr_hold", 64'(mem_address), 64'(addr_exp_q[0]));
          end else begin
            ea = addr_exp_q.pop_front();
            check("mem_address", 64'(mem_address), 64'(ea));
            pend_addr = ea;
            pend = rand_lat ? int'($urandom_range(1, 3)) : 1;
            req_idx++;
          end
        end
      end else begin
        mem_waitrequest = rand_wait && ($urandom_range(0, 1) == 0);
      end
    end
  end

  // monitor: every strobe pops one expected word; done must ride the last one
  initial begin
    logic [BITS-1:0] e;
    logic            l;
    forever begin
      @(negedge clk);
      if (!rst_n) continue;
      if (fifo_en) begin
        if (exp_q.size() == 0) begin
          fail("extra_fifo_en");
        end else begin
          e = exp_q.pop_front();
          l = last_q.pop_front();
          check("fifo_d", fifo_d, e);
          check("done_with_last", 64'(done), 64'(l));
          last_d = e;
          words_seen++;
          if (l) loads_done++;
        end
      end else begin
        check("fifo_d_hold", fifo_d, last_d);
        if (done) fail("done_without_fifo_en");
      end
    end
  end

  // driver tasks; begin_load is entered at a negedge
  task automatic begin_load(input logic [ADDR_W-1:0] base);
    logic [ADDR_W-1:0] a;
    salt = $urandom;
    base_addr = base;
    start = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      a = base + 32'(i * (BITS / 8));
      addr_exp_q.push_back(a);
      exp_q.push_back(mem_data(a));
      last_q.push_back(i == DEPTH - 1);
    end
    req_idx = 0;
    stall_left = stall_mode ? 3 : 0;
    stall_seen = 0;
    words_seen = 0;
    ld0 = loads_done;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic finish_load();
    int cyc;
    cyc = 0;
    while (loads_done == ld0 && cyc < TMO) begin
      @(negedge clk);
      cyc++;
      if (start_noise) begin
        start = busy && ($urandom_range(0, 2) == 0);
        base_addr = $urandom;
      end
    end
    start = 1'b0;
    if (cyc >= TMO) fail("load_timeout");
    @(negedge clk);
    check("busy_idle", 64'(busy), 64'd0);
    check("done_idle", 64'(done), 64'd0);
    check("words_per_load", 64'(words_seen), 64'(DEPTH));
    check("data_left", 64'(exp_q.size()), 64'd0);
    check("addr_left", 64'(addr_exp_q.size()), 64'd0);
`ifdef FIFO_LOADER_STALL_CNT_EN
    check("stall_cnt", 64'(stall_cnt), 64'(stall_seen));
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_read"}, 64'(mem_read), 64'd0);
    check({tag, "_mem_address"}, 64'(mem_address), 64'd0);
    check({tag, "_fifo_d"}, fifo_d, 64'd0);
    check({tag, "_fifo_en"}, 64'(fifo_en), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
`ifdef FIFO_LOADER_STALL_CNT_EN
    check({tag, "_stall_cnt"}, 64'(stall_cnt), 64'd0);
`endif
  endtask

  // main sequence
  initial begin
    int cyc;
    rst_n = 1'b0;
    #1;
    check_all_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // zero-wait load from 0x100, one-cycle data latency
    @(negedge clk);
    begin_load(32'h0000_0100);
    finish_load();

    // three stall cycles on the second request
    stall_mode = 1'b1;
    @(negedge clk);
    begin_load(32'h0000_0100);
    finish_load();
    check("stall_cycles_seen", 64'(stall_seen), 64'd3);
    stall_mode = 1'b0;

    // address wrap
    @(negedge clk);
    begin_load(32'hFFFF_FFF8);
    finish_load();

    // start noise while busy and spurious readdatavalid outside WAIT
    spur_en = 1'b1;
    start_noise = 1'b1;
    @(negedge clk);
    begin_load(32'h0000_0400);
    finish_load();
    spur_en = 1'b0;
    start_noise = 1'b0;

    // reset after the 4th word, then restart on the first edge after release
    rand_wait = 1'b1;
    rand_lat = 1'b1;
    @(negedge clk);
    begin_load(32'h0000_0300);
    cyc = 0;
    while (words_seen < 4 && cyc < TMO) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= TMO) fail("reset_wait_timeout");
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("midload_reset");
    exp_q.delete();
    last_q.delete();
    addr_exp_q.delete();
    last_d = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    begin_load(32'h0000_0200);
    finish_load();

    // randomised loads
    spur_en = 1'b1;
    start_noise = 1'b1;
    for (int n = 0; n < 20; n++) begin
      rand_wait = ($urandom_range(0, 1) == 1);
      rand_lat = ($urandom_range(0, 1) == 1);
      repeat ($urandom_range(1, 3)) @(negedge clk);
      begin_load($urandom);
      finish_load();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish at %0t", $time);
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/fifo_loader.md
FIFO_LOADER -- requirements
Module: fifo_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 8: number of words fetched per load, equal to the downstream delay buffer's depth.
REQ-002 SHALL have parameter BITS, default 64: data word width.
REQ-003 SHALL have parameter ADDR_W, default 32: byte address width.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1: load request, sampled only in IDLE.
REQ-007 SHALL have port base_addr  input  ADDR_W: byte address of the first word, latched on accepted start.
REQ-008 SHALL have port mem_address  output  ADDR_W: read address.
REQ-009 SHALL have port mem_read  output  1: read request.
REQ-010 SHALL have port mem_waitrequest  input  1: memory stall; a read is accepted in any cycle with mem_read=1 and mem_waitrequest=0.
REQ-011 SHALL have port mem_readdata  input  BITS: read data.
REQ-012 SHALL have port mem_readdatavalid  input  1: mem_readdata is valid this cycle.
REQ-013 SHALL have port fifo_d  output  BITS: word presented to the delay buffer.
REQ-014 SHALL have port fifo_en  output  1: one-cycle shift strobe to the delay buffer.
REQ-015 SHALL have port busy  output  1: high whenever state is not IDLE.
REQ-016 SHALL have port done  output  1: one-cycle pulse at load completion.

Function
REQ-017 SHALL implement states IDLE, REQ, WAIT and DONE, with exactly one read outstanding at any time.
REQ-018 SHALL, in IDLE with start=1, latch base_addr, clear the word counter (width clog2(DEPTH+1)), and enter REQ.
REQ-019 SHALL, in REQ, drive mem_read=1 and mem_address=base+count*(BITS/8), with the sum wrapping modulo 2^ADDR_W.
REQ-020 SHALL hold mem_address stable while mem_waitrequest=1, and enter WAIT on acceptance.
REQ-021 SHALL drive mem_read=0 in IDLE, WAIT and DONE.
REQ-022 SHALL, in WAIT with mem_readdatavalid=1, register mem_readdata into fifo_d, pulse fifo_en for the following cycle (1-cycle latency), and increment count.
REQ-023 SHALL go from WAIT to DONE on the DEPTH-th valid word, and otherwise return to REQ.
REQ-024 SHALL assert done=1 for exactly one cycle in DONE, coincident with the final fifo_en pulse, and then return to IDLE.
REQ-025 SHALL ignore start in REQ, WAIT and DONE, and ignore mem_readdatavalid outside WAIT.
REQ-026 SHALL hold fifo_d at its last value whenever fifo_en=0.
REQ-027 SHALL produce exactly DEPTH fifo_en pulses per load, in increasing address order.

Reset
REQ-028 SHALL, on rst_n=0 at any time including mid-load, immediately force IDLE, count=0, mem_read=0, mem_address=0, fifo_d=0, fifo_en=0, busy=0, done=0, and abandon any outstanding read.
REQ-029 SHALL, after reset release, accept a start in the first clock edge that sees rst_n=1.

Configuration
REQ-030 SHALL, when macro FIFO_LOADER_STALL_CNT_EN is defined, add output stall_cnt (16 bits), reset to 0.
REQ-031 SHALL clear stall_cnt on each accepted start and increment it on every cycle with mem_read=1 and mem_waitrequest=1, saturating at 0xFFFF.
REQ-032 SHALL, without FIFO_LOADER_STALL_CNT_EN, omit the stall_cnt port and its logic and leave all other behaviour identical.

Verification
REQ-033 SHALL cover zero-wait load: DEPTH=8, base_addr=0x100, data returned 1 cycle after acceptance -> addresses 0x100..0x138 step 8, and 8 fifo_en pulses carrying data in address order, with done coincident with the 8th pulse.
REQ-034 SHALL cover stalls: mem_waitrequest=1 for 3 cycles on the 2nd request -> mem_address held at 0x108 for those cycles, with no extra fifo_en, and stall_cnt=3 when the macro is defined.
REQ-035 SHALL cover address wrap: base_addr=0xFFFFFFF8 -> 2nd address 0x00000000.
REQ-036 SHALL cover ignored inputs: start pulsed during WAIT and a spurious mem_readdatavalid during REQ -> no restart and no fifo_en, with the load completing normally.
REQ-037 SHALL cover mid-load reset: rst_n low after the 4th word -> all outputs 0 immediately, and a new start at 0x200 then yields 8 fresh words from 0x200.
